// File: rtl/shift_reg_ctrl.sv
// Serial/parallel shift-register controller: one transmit or receive transfer
// of 1..WIDTH bits per start request, with abort and a one-cycle done pulse.
module shift_reg_ctrl #(
  parameter  int WIDTH = 8,
  localparam int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             dir,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  input  logic             abort,
  output logic             sout,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] eff_len;
  logic             shift_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  // A zero or oversized length request means a full-width transfer.
  assign eff_len  = ((len == '0) || (len > FULL_LEN)) ? FULL_LEN : len;
  assign shift_in = mode_q ? sin : 1'b0;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          dir_d   = dir;
          cnt_d   = eff_len;
          sreg_d  = mode ? '0 : din;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Abort wins over the final shift, so the register freezes where it is.
        if (abort) begin
          state_d = IDLE;
        end else begin
          sreg_d = dir_q ? {sreg_q[WIDTH-2:0], shift_in}
                         : {shift_in, sreg_q[WIDTH-1:1]};
          cnt_d  = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign dout = sreg_q;
  assign sout = ((state_q == SHIFT) && !mode_q) ? (dir_q ? sreg_q[WIDTH-1] : sreg_q[0])
                                                : 1'b0;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl: directed vector table, randomized
// transfers against a bit-list reference model, and abort/reset/len corner cases.
module tb_shift_reg_ctrl;

  localparam int W = 8;
  localparam int LW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic          dir;
  logic [LW-1:0] len;
  logic [W-1:0]  din;
  logic          sin;
  logic          abort;
  logic          sout;
  logic [W-1:0]  dout;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  shift_reg_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
    .len(len), .din(din), .sin(sin), .abort(abort),
    .sout(sout), .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic          dir;
    logic [LW-1:0] len;
    logic [W-1:0]  din;
    logic [W-1:0]  sin_bits;   // bit i = serial bit presented in shift cycle i
    int            n;
    logic [W-1:0]  exp_sout;   // bit i = expected sout in shift cycle i
    logic [W-1:0]  exp_dout;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: transfer expressed as an ordered list of bits.
  function automatic int eff_len(input logic [LW-1:0] l);
    return (l == 0 || int'(l) > W) ? W : int'(l);
  endfunction

  function automatic logic [W-1:0] model_sout(input logic d, input int n, input logic [W-1:0] word);
    logic [W-1:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = d ? word[W-1-i] : word[i];
    return v;
  endfunction

  function automatic logic [W-1:0] model_dout(input logic m, input logic d, input int n,
                                              input logic [W-1:0] word, input logic [W-1:0] bits);
    logic [W-1:0] r = '0;
    if (!m) begin
      r = d ? (word << n) : (word >> n);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (d) r[n-1-i] = bits[i];
        else   r[W-n+i] = bits[i];
      end
    end
    return r;
  endfunction

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic run_xfer(input string name, input vec_t v);
    start = 1'b1; mode = v.mode; dir = v.dir; len = v.len; din = v.din;
    @(posedge clk); #1;
    start = 1'b0; din = W'($urandom);
    for (int i = 0; i < v.n; i++) begin
      sin = v.sin_bits[i];
      @(negedge clk);
      chk({name, " busy_shift"}, 32'(busy), 32'd1);
      chk({name, " done_early"}, 32'(done), 32'd0);
      chk({name, " sout"}, 32'(sout), v.mode ? 32'd0 : 32'(v.exp_sout[i]));
      @(posedge clk); #1;
    end
    sin = 1'b0;
    @(negedge clk);
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " dout"}, 32'(dout), 32'(v.exp_dout));
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
    chk({name, " done_after"}, 32'(done), 32'd0);
    chk({name, " dout_hold"}, 32'(dout), 32'(v.exp_dout));
    @(posedge clk); #1;
  endtask

  initial begin
    int done_cnt;
    int done_cyc;
    vec_t rv;

    //        mode  dir   len    din    sin_bits n  exp_sout exp_dout
    tbl[0] = '{1'b0, 1'b0, 4'd8, 8'hB2, 8'h00, 8, 8'hB2, 8'h00};  // TX right
    tbl[1] = '{1'b0, 1'b1, 4'd4, 8'hB2, 8'h00, 4, 8'h0D, 8'h20};  // TX left, 1,0,1,1
    tbl[2] = '{1'b1, 1'b0, 4'd8, 8'h00, 8'hC5, 8, 8'h00, 8'hC5};  // RX right 1,0,1,0,0,0,1,1
    tbl[3] = '{1'b1, 1'b1, 4'd3, 8'hFF, 8'h03, 3, 8'h00, 8'h06};  // RX left 1,1,0
    tbl[4] = '{1'b0, 1'b1, 4'd0, 8'h81, 8'h00, 8, 8'h81, 8'h00};  // len 0 -> 8
    tbl[5] = '{1'b0, 1'b0, 4'd9, 8'h5A, 8'h00, 8, 8'h5A, 8'h00};  // len 9 -> 8
    tbl[6] = '{1'b1, 1'b0, 4'd2, 8'h00, 8'h03, 2, 8'h00, 8'hC0};  // RX right partial
    tbl[7] = '{1'b0, 1'b0, 4'd1, 8'h03, 8'h00, 1, 8'h01, 8'h01};  // single bit

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; dir = 1'b0; len = '0;
    din = '0; sin = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sout", 32'(sout), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) run_xfer($sformatf("vec%0d", t), tbl[t]);

    for (int r = 0; r < 25; r++) begin
      rv.mode     = 1'($urandom);
      rv.dir      = 1'($urandom);
      rv.len      = LW'($urandom);
      rv.din      = W'($urandom);
      rv.sin_bits = W'($urandom);
      rv.n        = eff_len(rv.len);
      rv.exp_sout = model_sout(rv.dir, rv.n, rv.din);
      rv.exp_dout = model_dout(rv.mode, rv.dir, rv.n, rv.din, rv.sin_bits);
      run_xfer($sformatf("rand%0d", r), rv);
    end

    // len=0 with a second start while busy: one transfer, one done pulse.
    start = 1'b1; mode = 1'b0; dir = 1'b0; len = '0; din = 8'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin start = 1'b1; mode = 1'b1; din = 8'hFF; len = 4'd2; end
      else start = 1'b0;
      @(negedge clk);
      if (c <= 8) chk($sformatf("busystart sout c%0d", c), 32'(sout), 32'(din_bit(8'hA5, c - 1)));
      if (done) begin done_cnt++; done_cyc = c; end
      if (c == 10) chk("busystart idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busystart done count", 32'(done_cnt), 32'd1);
    chk("busystart done cycle", 32'(done_cyc), 32'd9);
    chk("busystart dout", 32'(dout), 32'd0);

    // Abort in shift cycle 3 freezes the register and suppresses done.
    start = 1'b1; mode = 1'b0; dir = 1'b0; len = 4'd8; din = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      abort = (c == 3);
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 4) begin
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort dout", 32'(dout), 32'h0F);
        chk("abort sout", 32'(sout), 32'd0);
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    chk("abort no done", 32'(done_cnt), 32'd0);
    run_xfer("after_abort", tbl[0]);

    // Reset in shift cycle 5 clears everything with no done pulse.
    start = 1'b1; mode = 1'b1; dir = 1'b0; len = 4'd8; sin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      rst_n = (c != 5);
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 6) begin
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst dout", 32'(dout), 32'd0);
        chk("rst sout", 32'(sout), 32'd0);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1; sin = 1'b0;
    chk("rst no done", 32'(done_cnt), 32'd0);
    run_xfer("after_rst", tbl[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic din_bit(input logic [W-1:0] word, input int i);
    return word[i];
  endfunction

endmodule
